// File: rtl/cmp_monitor.sv
// cmp_monitor: registered compare-and-qualify unit with run-length count,
// debounced hit after HOLD consecutive matches, and a software-cleared sticky flag.
module cmp_monitor #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8,
  parameter int HOLD  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in,
  input  logic [WIDTH-1:0] ref_val,
  input  logic [1:0]       mode,
  input  logic             clr,
  output logic             zer,
  output logic             out_valid,
  output logic [CNT_W-1:0] run_cnt,
  output logic             hit,
  output logic             sticky
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W:0]   HOLD_C  = (CNT_W+1)'(HOLD);

  logic             zer_q;
  logic             ov_q;
  logic [CNT_W-1:0] run_q, run_d;
  logic             hit_q, hit_d;
  logic             hit_dly_q;
  logic             stk_q, stk_d;
  logic [1:0]       mode_q;

  logic             match;
  logic [CNT_W-1:0] base;
  logic [CNT_W:0]   inc;

  always_comb begin
    match = 1'b0;
    unique case (mode)
      2'b00: match = (in == '0);
      2'b01: match = (in == ref_val);
      2'b10: match = (in < ref_val);
      2'b11: match = (in > ref_val);
      default: match = 1'b0;
    endcase
  end

  // A mode change restarts the run from an empty base.
  always_comb begin
    base  = (mode != mode_q) ? '0 : run_q;
    inc   = {1'b0, base} + 1'b1;
    run_d = '0;
    if (match)
      run_d = inc[CNT_W] ? CNT_MAX : inc[CNT_W-1:0];
    hit_d = match && (inc >= HOLD_C);
  end

  // Rising edge of hit sets sticky; set beats clr.
  always_comb begin
    stk_d = stk_q;
    if (hit_q && !hit_dly_q)
      stk_d = 1'b1;
    else if (clr)
      stk_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      zer_q     <= 1'b0;
      ov_q      <= 1'b0;
      run_q     <= '0;
      hit_q     <= 1'b0;
      hit_dly_q <= 1'b0;
      stk_q     <= 1'b0;
      mode_q    <= 2'b00;
    end else begin
      ov_q      <= in_valid;
      hit_dly_q <= hit_q;
      stk_q     <= stk_d;
      if (in_valid) begin
        zer_q  <= match;
        mode_q <= mode;
        run_q  <= run_d;
        hit_q  <= hit_d;
      end
    end
  end

  assign zer       = zer_q;
  assign out_valid = ov_q;
  assign run_cnt   = run_q;
  assign hit       = hit_q;
  assign sticky    = stk_q;

endmodule

// File: tb/tb_cmp_monitor.sv
// Bench for cmp_monitor: two configurations driven in parallel, checked
// every cycle against a run-length model plus directed literal checks.
module tb_cmp_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in;
  logic [15:0] ref_val;
  logic [1:0]  mode;
  logic        clr;

  logic       zer0, ov0, hit0, stk0;
  logic [7:0] cnt0;
  logic       zer1, ov1, hit1, stk1;
  logic [2:0] cnt1;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  cmp_monitor #(.WIDTH(16), .CNT_W(8), .HOLD(4)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in),
    .ref_val(ref_val), .mode(mode), .clr(clr),
    .zer(zer0), .out_valid(ov0), .run_cnt(cnt0),
    .hit(hit0), .sticky(stk0)
  );

  cmp_monitor #(.WIDTH(16), .CNT_W(3), .HOLD(2)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in),
    .ref_val(ref_val), .mode(mode), .clr(clr),
    .zer(zer1), .out_valid(ov1), .run_cnt(cnt1),
    .hit(hit1), .sticky(stk1)
  );

  // Model: unbounded run length of consecutive matches in the same mode.
  int hold_p[2]  = '{4, 2};
  int max_p[2]   = '{255, 7};
  int run[2];
  int mq[2];
  bit ezer[2], eov[2], ehit[2], ehp[2], estk[2];

  function automatic bit m_match(int md, int a, int b);
    case (md)
      0: return a == 0;
      1: return a == b;
      2: return a < b;
      default: return a > b;
    endcase
  endfunction

  always @(posedge clk) begin
    bit m;
    bit set;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        run[k] = 0; mq[k] = 0; ezer[k] = 0; eov[k] = 0;
        ehit[k] = 0; ehp[k] = 0; estk[k] = 0;
      end else begin
        set = ehit[k] && !ehp[k];
        ehp[k] = ehit[k];
        if (set) estk[k] = 1;
        else if (clr) estk[k] = 0;
        eov[k] = in_valid;
        if (in_valid) begin
          m = m_match(int'(mode), int'(in), int'(ref_val));
          if (!m) run[k] = 0;
          else if (int'(mode) != mq[k]) run[k] = 1;
          else run[k] = run[k] + 1;
          mq[k] = int'(mode);
          ezer[k] = m;
          ehit[k] = m && (run[k] >= hold_p[k]);
        end
      end
    end
  end

  task automatic cmp(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("d0.zer", int'(zer0), int'(ezer[0]));
      cmp("d0.out_valid", int'(ov0), int'(eov[0]));
      cmp("d0.run_cnt", int'(cnt0), (run[0] > max_p[0]) ? max_p[0] : run[0]);
      cmp("d0.hit", int'(hit0), int'(ehit[0]));
      cmp("d0.sticky", int'(stk0), int'(estk[0]));
      cmp("d1.zer", int'(zer1), int'(ezer[1]));
      cmp("d1.out_valid", int'(ov1), int'(eov[1]));
      cmp("d1.run_cnt", int'(cnt1), (run[1] > max_p[1]) ? max_p[1] : run[1]);
      cmp("d1.hit", int'(hit1), int'(ehit[1]));
      cmp("d1.sticky", int'(stk1), int'(estk[1]));
    end
  end

  task automatic step(bit r, bit v, int d, int rv, int md, bit c);
    rst = r; in_valid = v; in = 16'(d); ref_val = 16'(rv);
    mode = 2'(md); clr = c;
    @(negedge clk);
  endtask

  int gap_cnt[7] = '{1, 2, 2, 2, 2, 3, 4};
  int gap_v[7]   = '{1, 1, 0, 0, 0, 1, 1};

  initial begin
    rst = 1; in_valid = 0; in = 0; ref_val = 0; mode = 0; clr = 0;
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk_en = 1'b1;
    cmp("lit.rst.zer", int'(zer0), 0);
    cmp("lit.rst.ov", int'(ov0), 0);
    cmp("lit.rst.cnt", int'(cnt0), 0);
    cmp("lit.rst.hit", int'(hit0), 0);
    cmp("lit.rst.stk", int'(stk0), 0);

    step(0, 1, 16'h0000, 0, 0, 0);
    cmp("lit.first.zer", int'(zer0), 1);
    cmp("lit.first.cnt", int'(cnt0), 1);
    cmp("lit.first.ov", int'(ov0), 1);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    cmp("lit.deb3.hit", int'(hit0), 0);
    step(0, 1, 0, 0, 0, 0);
    cmp("lit.deb4.hit", int'(hit0), 1);
    cmp("lit.deb4.stk", int'(stk0), 0);
    step(0, 1, 16'h0001, 0, 0, 0);
    cmp("lit.deb5.zer", int'(zer0), 0);
    cmp("lit.deb5.cnt", int'(cnt0), 0);
    cmp("lit.deb5.hit", int'(hit0), 0);
    cmp("lit.deb5.stk", int'(stk0), 1);

    for (int i = 0; i < 7; i++) begin
      step(0, gap_v[i], 16'h1234, 16'h1234, 1, 0);
      cmp("lit.gap.cnt", int'(cnt0), gap_cnt[i]);
    end
    cmp("lit.gap.hit", int'(hit0), 1);
    step(0, 0, 0, 16'h1234, 1, 0);
    step(0, 0, 0, 16'h1234, 1, 1);
    cmp("lit.clr.stk", int'(stk0), 0);
    step(0, 1, 0, 16'h1234, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 16'h1234, 16'h1234, 1, 0);
    cmp("lit.rise.hit", int'(hit0), 1);
    step(0, 0, 0, 16'h1234, 1, 1);
    cmp("lit.clrset.stk", int'(stk0), 1);

    step(0, 1, 16'h7FFF, 16'h8000, 2, 0);
    cmp("lit.lt.yes", int'(zer0), 1);
    step(0, 1, 16'h8000, 16'h8000, 2, 0);
    cmp("lit.lt.eq", int'(zer0), 0);
    step(0, 1, 16'h8001, 16'h8000, 3, 0);
    cmp("lit.gt.yes", int'(zer0), 1);
    step(0, 1, 16'hFFFF, 16'h8000, 3, 0);
    cmp("lit.gt.max", int'(zer0), 1);

    step(1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 9; i++) begin
      step(0, 1, 0, 0, 0, 0);
      cmp("lit.sat.cnt", int'(cnt1), (i > 7) ? 7 : i);
      cmp("lit.sat.hit", int'(hit1), (i >= 2) ? 1 : 0);
    end
    step(0, 1, 5, 5, 1, 0);
    cmp("lit.mchg.cnt", int'(cnt1), 1);
    cmp("lit.mchg.hit", int'(hit1), 0);
    step(0, 1, 5, 5, 1, 0);
    cmp("lit.mid.hit", int'(hit1), 1);
    step(1, 1, 5, 5, 1, 1);
    cmp("lit.mid.cnt", int'(cnt1), 0);
    cmp("lit.mid.hit0", int'(hit1), 0);
    cmp("lit.mid.ov", int'(ov1), 0);
    cmp("lit.mid.stk", int'(stk1), 0);
    step(0, 1, 5, 5, 1, 0);
    cmp("lit.after.cnt", int'(cnt1), 1);

    for (int i = 0; i < 3000; i++) begin
      int md, rv, d, sel;
      if ($urandom_range(15) == 0) md = $urandom_range(3);
      else md = int'(mode);
      rv = $urandom_range(65535);
      sel = $urandom_range(7);
      case (sel)
        0, 1, 2: d = (md == 0) ? 0 : rv;
        3: d = (rv > 0) ? rv - 1 : 0;
        4: d = (rv < 65535) ? rv + 1 : rv;
        5: d = 0;
        default: d = $urandom_range(65535);
      endcase
      if (md >= 2 && sel < 3) d = (md == 2) ? rv / 2 : rv + (65535 - rv) / 2 + 1;
      if (d > 65535) d = 65535;
      step($urandom_range(199) == 0, $urandom_range(3) != 0, d, rv, md,
           $urandom_range(15) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cmp_monitor.md
# cmp_monitor

Parametrised, registered compare-and-qualify unit: the successor to the single-width zero detector. Each valid sample is compared against zero or a reference value in one of four modes. The unit produces a registered per-sample match flag, a saturating run-length count of consecutive matches, a debounced `hit` after HOLD consecutive matches, and a sticky event flag cleared by software. It sits on datapath status buses (accumulators, counters, ALU results), where the control FSMs need qualified conditions rather than raw compares.

## Interface
- `WIDTH`, 16: compared data width.
- `CNT_W`, 8: run-length counter width.
- `HOLD`, 4: consecutive matches required for `hit`. Legal range 1 .. 2^CNT_W-1.

- `clk` in 1: single clock. All state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: `in` carries a sample this cycle.
- `in` in WIDTH: sample, unsigned.
- `ref_val` in WIDTH: reference value, unsigned, sampled with `in`.
- `mode` in 2: compare mode, sampled with `in`.
- `clr` in 1: clears `sticky`.
- `zer` out 1: registered match result of the last valid sample.
- `out_valid` out 1: `zer`/`run_cnt`/`hit` updated this cycle.
- `run_cnt` out CNT_W: consecutive matching valid samples, saturating.
- `hit` out 1: match has held for at least HOLD consecutive samples.
- `sticky` out 1: set on any rising edge of `hit`, held until `clr`.

## Operation
- Match m, by `mode`:
  - 00: `in` == 0.
  - 01: `in` == `ref_val`.
  - 10: `in` < `ref_val` (unsigned).
  - 11: `in` > `ref_val` (unsigned).
- Internal `mode_q` (reset 00) holds the mode of the previous valid sample.
- Base value: base = 0 if `mode` != `mode_q`, else `run_cnt`. A mode change restarts the run.
- On a valid sample:
  - `zer` <= m.
  - `mode_q` <= `mode`.
  - `run_cnt` <= m ? min(base+1, 2^CNT_W-1) : 0.
  - `hit` <= m && (base+1 >= HOLD).
- `in_valid` low: `zer`, `run_cnt`, `hit`, `mode_q` hold. Idle cycles do not break a run.
- `sticky` is set when `hit` goes from 0 to 1. If `clr` and the set condition occur in the same cycle, set wins. `clr` with no set clears `sticky` next cycle.
- State machine, tracked in `run_cnt`:
  - IDLE (`run_cnt`=0): match goes to COUNT, or to HIT if HOLD=1. Mismatch stays in IDLE.
  - COUNT (0 < `run_cnt` < HOLD): match increments; base+1 = HOLD goes to HIT. Mismatch goes to IDLE.
  - HIT (`run_cnt` >= HOLD): match stays in HIT, count saturating. Mismatch goes to IDLE. A mode change restarts from 1 and leaves HIT unless HOLD=1.
- Saturation: `run_cnt` stops at 2^CNT_W-1. `hit` stays high while matches continue.

## Timing
- Latency is 1 cycle, from the valid sample edge to `zer`, `run_cnt`, `hit`, and `out_valid` (= registered `in_valid`).
- `sticky` rises 1 cycle after `hit` rises.
- Reset values, all outputs: `zer`=0, `out_valid`=0, `run_cnt`=0, `hit`=0, `sticky`=0. `mode_q`=00.
- `rst` has priority over all inputs, including mid-run and in the same cycle as `in_valid` or `clr`. The first valid sample after reset starts from an empty run.
- Back-to-back valid samples are accepted every cycle. There is no backpressure.

## Test plan
- Reset then idle: `rst`=1 for 2 cycles, `in_valid`=0 -> all outputs 0. `in_valid`=1, `in`=0x0000, `mode`=00 -> next cycle `zer`=1, `run_cnt`=1, `out_valid`=1.
- Debounce with HOLD=4: feed four valid samples of 0x0000 -> `hit` rises on the cycle after the 4th, `sticky` rises one cycle later. A 5th sample of 0x0001 -> `zer`=0, `run_cnt`=0, `hit`=0; `sticky` stays 1.
- Gaps and sticky clear: in mode 01 with `ref_val`=0x1234, feed 0x1234 ×2, then `in_valid`=0 ×3, then 0x1234 ×2 -> `run_cnt` 1,2,2,2,2,3,4 and `hit` asserted at the final step. Pulse `clr` with no set -> `sticky`=0 next cycle. `clr` in the same cycle as a `hit` rise -> `sticky`=1.
- Magnitude modes: `ref_val`=0x8000. Mode 10 with `in`=0x7FFF -> `zer`=1; `in`=0x8000 -> `zer`=0. Mode 11 with `in`=0x8001 -> `zer`=1; `in`=0xFFFF -> `zer`=1.
- Mode change and saturation, with CNT_W=3 and HOLD=2: 9 matching samples in mode 00 -> `run_cnt` saturates at 7, `hit`=1 throughout from sample 2. A matching sample in mode 01 -> `run_cnt`=1, `hit`=0.
- Reset mid-run: assert `rst` in the same cycle as a valid matching sample while `hit`=1 -> all outputs 0 next cycle. The next match yields `run_cnt`=1.
